// File: rtl/mlp_load_buffer_pkg.sv
// Shared types and constants for the MLP load buffer.
// Matrix geometry, element types and load FSM states.
package mlp_pkg;

    localparam int DATA_W        = 16;
    localparam int DIM           = 16;
    localparam int WORDS_PER_MAT = DIM * DIM / 2;
    localparam int ROW_W         = $clog2(DIM);
    localparam int PAIR_W        = $clog2(DIM / 2);
    localparam int CNT_W         = $clog2(WORDS_PER_MAT);

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [DIM-1:0]   row_t;

    typedef enum logic [1:0] {
        LOAD_X,
        LOAD_W,
        FULL
    } load_state_e;

endpackage

// File: rtl/mlp_load_buffer_if.sv
// Load stream and buffer status bundle.
// Master is the feeder/controller, slave is the buffer.
interface mlp_load_buffer_if;
    import mlp_pkg::*;

    logic              load_en_i;
    logic [2*DATA_W-1:0] load_payload_i;
    logic              load_ready_o;
    logic              buf_full_o;
    logic              load_done_o;
    logic              overflow_o;
    logic              buf_release_i;

    modport master (
        output load_en_i,
        output load_payload_i,
        output buf_release_i,
        input  load_ready_o,
        input  buf_full_o,
        input  load_done_o,
        input  overflow_o
    );

    modport slave (
        input  load_en_i,
        input  load_payload_i,
        input  buf_release_i,
        output load_ready_o,
        output buf_full_o,
        output load_done_o,
        output overflow_o
    );

endinterface

// File: rtl/mlp_load_buffer_mat_store.sv
// DIM x DIM element store, two-element packed write port.
// Registered read: whole row, or a column pair when COL_READ.
module mlp_mat_store
    import mlp_pkg::*;
#(
    parameter  bit COL_READ = 1'b0,
    localparam int SEL_W    = COL_READ ? ROW_W + PAIR_W : ROW_W,
    localparam int RD_W     = COL_READ ? 2 * DATA_W : DIM * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ROW_W-1:0]  i_row,
    input  logic [PAIR_W-1:0] i_pair,
    input  logic [2*DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [RD_W-1:0]   o_rd
);

    row_t            r_mem [DIM];
    logic [RD_W-1:0] r_rd;

    // Storage write: low half to even column, high half to odd column.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_row][{i_pair, 1'b0}] <= i_data[DATA_W-1:0];
            r_mem[i_row][{i_pair, 1'b1}] <= i_data[2*DATA_W-1:DATA_W];
        end
    end

    generate
        if (COL_READ) begin : g_col
            logic [ROW_W-1:0]  w_col;
            logic [PAIR_W-1:0] w_pr;
            assign w_col = i_sel[ROW_W-1:0];
            assign w_pr  = i_sel[SEL_W-1:ROW_W];
            // Column-pair read register: {W[2p+1][c], W[2p][c]}.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd <= '0;
                end else begin
                    r_rd <= {r_mem[{w_pr, 1'b1}][w_col],
                             r_mem[{w_pr, 1'b0}][w_col]};
                end
            end
        end else begin : g_row
            // Row read register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd <= '0;
                end else begin
                    r_rd <= r_mem[i_sel];
                end
            end
        end
    endgenerate

    assign o_rd = r_rd;

endmodule

// File: rtl/mlp_load_buffer.sv
// Load buffer feeding the PE array: fills X then W from the
// 32-bit stream, holds both until released, serves reads.
module mlp_load_buffer
    import mlp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    mlp_load_buffer_if.slave      bus,
    input  logic [ROW_W-1:0]      x_row_idx_i,
    output logic [DIM*DATA_W-1:0] x_row_o,
    input  logic [ROW_W-1:0]      w_col_idx_i,
    input  logic [PAIR_W-1:0]     w_pair_idx_i,
    output logic [2*DATA_W-1:0]   w_pair_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_MAT - 1);

    load_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_full;
    logic             r_done;
    logic             r_ovf;

    logic w_we_x;
    logic w_we_w;

    assign w_we_x = bus.load_en_i && (r_state == LOAD_X);
    assign w_we_w = bus.load_en_i && (r_state == LOAD_W);

    // Load FSM, word counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_X;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                LOAD_X: begin
                    if (bus.load_en_i) begin
                        if (r_cnt == LAST) begin
                            r_state <= LOAD_W;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_W: begin
                    if (bus.load_en_i) begin
                        if (r_cnt == LAST) begin
                            r_state <= FULL;
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                            r_full  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.load_en_i) begin
                        r_ovf <= 1'b1;
                    end
                    if (bus.buf_release_i) begin
                        r_state <= LOAD_X;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD_X;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.load_ready_o = r_ready;
    assign bus.buf_full_o   = r_full;
    assign bus.load_done_o  = r_done;
    assign bus.overflow_o   = r_ovf;

    mlp_mat_store #(.COL_READ(1'b0)) u_x (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_x),
        .i_row  (r_cnt[CNT_W-1:PAIR_W]),
        .i_pair (r_cnt[PAIR_W-1:0]),
        .i_data (bus.load_payload_i),
        .i_sel  (x_row_idx_i),
        .o_rd   (x_row_o)
    );

    mlp_mat_store #(.COL_READ(1'b1)) u_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_w),
        .i_row  (r_cnt[CNT_W-1:PAIR_W]),
        .i_pair (r_cnt[PAIR_W-1:0]),
        .i_data (bus.load_payload_i),
        .i_sel  ({w_pair_idx_i, w_col_idx_i}),
        .o_rd   (w_pair_o)
    );

endmodule
